// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 vending keypad scanner: FSM states, key codes and
// the row-priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_CHIPS     = 4'h0;
  localparam key_code_t KEY_COKE      = 4'h1;
  localparam key_code_t KEY_COOKIE    = 4'h2;
  localparam key_code_t KEY_ICE_CREAM = 4'h3;
  localparam key_code_t KEY_COFFEE    = 4'h4;
  localparam key_code_t KEY_INC       = 4'h5;
  localparam key_code_t KEY_DONE      = 4'h6;
  localparam key_code_t KEY_CONFIRM   = 4'h7;
  localparam key_code_t KEY_COIN2     = 4'h8;
  localparam key_code_t KEY_COIN5     = 4'h9;
  localparam key_code_t KEY_COIN10    = 4'hA;
  localparam key_code_t KEY_TAKE      = 4'hB;
  localparam key_code_t KEY_START     = 4'hF;

  // Lowest-index active-low row wins when several rows are down.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous row pins; idles high to match
// the external pull-ups so reset never looks like a key.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounced press/release and one-cycle key
// pulses. Define KEYPAD_REPEAT_EN to build the held-key auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic      clk,
  input  logic      reset,
  output logic [3:0] c,
  input  logic [3:0] r,
  output logic      key_valid,
  output key_code_t key_code,
  output logic      key_held
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CNT - 1);

  state_t       state, state_n;
  logic [1:0]   col, col_n, row, row_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] db, db_n;
  logic [3:0]   pat, pat_n, r_s;
  key_code_t    code_n;
  logic         valid_n, held_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rep, rep_n;
  logic          first_rep, first_rep_n;
`endif

  keypad_sync #(.W(4)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (r),
    .q    (r_s)
  );

  assign c = ~(4'b0001 << col);

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    dwell_n = dwell;
    db_n    = db;
    pat_n   = pat;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_n       = rep;
    first_rep_n = first_rep;
`endif
    case (state)
      SCAN: begin
        if (dwell != DWELL_LAST) begin
          dwell_n = dwell + 1'b1;
        end else if (r_s == 4'hF) begin
          col_n   = col + 2'd1;
          dwell_n = '0;
        end else begin
          pat_n   = r_s;
          row_n   = low_row(r_s);
          db_n    = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (r_s != pat) begin
          col_n   = col + 2'd1;
          dwell_n = '0;
          state_n = SCAN;
        end else if (db == DB_LAST) begin
          code_n  = {col, row};
          valid_n = 1'b1;
          held_n  = 1'b1;
          state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_n       = '0;
          first_rep_n = 1'b1;
`endif
        end else begin
          db_n = db + 1'b1;
        end
      end
      HELD: begin
        // Column stays frozen here, so keys in other columns are invisible.
        if (r_s == 4'hF) begin
          db_n    = '0;
          state_n = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep == (first_rep ? DELAY_LAST : RATE_LAST)) begin
          valid_n     = 1'b1;
          rep_n       = '0;
          first_rep_n = 1'b0;
        end else begin
          rep_n = rep + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (r_s != 4'hF) begin
          db_n = '0;
        end else if (db == DB_LAST) begin
          held_n  = 1'b0;
          col_n   = col + 2'd1;
          dwell_n = '0;
          state_n = SCAN;
        end else begin
          db_n = db + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      dwell     <= '0;
      db        <= '0;
      pat       <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
      first_rep <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      dwell     <= dwell_n;
      db        <= db_n;
      pat       <= pat_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
`ifdef KEYPAD_REPEAT_EN
      rep       <= rep_n;
      first_rep <= first_rep_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 key matrix drives the
// row pins from the scanned column; pulses are logged on the falling edge.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] c, r;
  logic       key_valid, key_held;
  key_code_t  key_code;

  // pressed[col] is a row mask, 1 = key down
  logic [3:0][3:0] pressed;

  int checks = 0, failures = 0;
  int cyc = 0, pulses = 0;
  int pulse_at[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(8),
    .REPEAT_DELAY(40),
    .REPEAT_RATE (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .c        (c),
    .r        (r),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  always_comb begin
    r = 4'hF;
    for (int k = 0; k < 4; k++)
      if (!c[k]) r = r & ~pressed[k];
  end

  always @(negedge clk) begin
    cyc++;
    if (key_valid) begin
      pulses++;
      pulse_at.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int p0 = pulses;
    int n  = 0;
    while (pulses == p0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_pulse_seen"}, 32'(pulses != p0), 32'd1);
  endtask

  task automatic wait_release(input string tag, input int budget);
    int n = 0;
    while (key_held && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_released"}, 32'(key_held), 32'd0);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] want, input int budget);
    int n = 0;
    while (c !== want && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(c), 32'(want));
  endtask

  logic [3:0] col_pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  int p, pb, t0;
  int off [5] = '{0, 40, 56, 72, 88};

  initial begin
    reset   = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_c", 32'(c), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);

    // 1: idle scan, four cycles per column
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan_c_%0d", i), 32'(c), 32'(col_pat[i/4]));
      tick();
    end
    chk("idle_no_pulse", 32'(pulses), 32'd0);

    // 2: coin 5 (c2/r1), clean press and release
    pb = pulses;
    p  = cyc;
    pressed[2] = 4'b0010;
    wait_pulse("t2", 40);
    chk("t2_latency_ok", 32'((cyc - p) <= 27), 32'd1);
    chk("t2_code", 32'(key_code), 32'(KEY_COIN5));
    chk("t2_held", 32'(key_held), 32'd1);
    tick();
    chk("t2_one_cycle", 32'(key_valid), 32'd0);
    repeat (20) tick();
    chk("t2_single_pulse", 32'(pulses - pb), 32'd1);
    chk("t2_held_still", 32'(key_held), 32'd1);
    pressed = '0;
    repeat (10) tick();
    chk("t2_held_in_release", 32'(key_held), 32'd1);
    tick();
    chk("t2_held_cleared", 32'(key_held), 32'd0);
    chk("t2_resume_col3", 32'(c), 32'h7);
    chk("t2_no_extra", 32'(pulses - pb), 32'd1);

    // 3: cookie (c0/r2) bouncing every 3 cycles, then stable
    pb = pulses;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[0][2] = ~pressed[0][2];
      tick();
    end
    chk("t3_bounce_quiet", 32'(pulses - pb), 32'd0);
    pressed[0] = 4'b0100;
    wait_pulse("t3", 40);
    chk("t3_code", 32'(key_code), 32'(KEY_COOKIE));
    pressed = '0;
    wait_release("t3", 30);
    chk("t3_single_pulse", 32'(pulses - pb), 32'd1);

    // 4: rows 1 and 3 in column 1, then a column-3 key while held
    pb = pulses;
    pressed[1] = 4'b1010;
    wait_pulse("t4", 40);
    chk("t4_code", 32'(key_code), 32'(KEY_INC));
    pressed[3] = 4'b0001;
    repeat (20) tick();
    chk("t4_ignored", 32'(pulses - pb), 32'd1);
    chk("t4_code_kept", 32'(key_code), 32'(KEY_INC));
    chk("t4_col_frozen", 32'(c), 32'hD);
    pressed[3] = 4'b0000;
    tick();
    pressed[1] = 4'b0000;
    wait_release("t4", 30);
    repeat (20) tick();
    chk("t4_no_late_pulse", 32'(pulses - pb), 32'd1);

    // 5: reset in the middle of debouncing START (c3/r3)
    pb = pulses;
    wait_col("t5_at_col0", 4'hE, 20);
    pressed[3] = 4'b1000;
    wait_col("t5_at_col3", 4'h7, 20);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("t5_rst_c", 32'(c), 32'hE);
    chk("t5_rst_valid", 32'(key_valid), 32'd0);
    chk("t5_rst_held", 32'(key_held), 32'd0);
    chk("t5_rst_code", 32'(key_code), 32'd0);
    pressed = '0;
    reset   = 1'b0;
    repeat (30) tick();
    chk("t5_no_pulse", 32'(pulses - pb), 32'd0);

    // 6: hold chips (c0/r0) for 100 cycles past the first pulse
    pb = pulses;
    pressed[0] = 4'b0001;
    wait_pulse("t6", 40);
    chk("t6_code", 32'(key_code), 32'(KEY_CHIPS));
    t0 = pulse_at[pb];
    repeat (100) tick();
    chk("t6_held", 32'(key_held), 32'd1);
`ifdef KEYPAD_REPEAT_EN
    chk("t6_repeat_count", 32'(pulses - pb), 32'd5);
    for (int k = 1; k < 5 && pb + k < pulses; k++)
      chk($sformatf("t6_repeat_at_%0d", k), 32'(pulse_at[pb+k] - t0), 32'(off[k]));
    chk("t6_code_repeat", 32'(key_code), 32'(KEY_CHIPS));
`else
    chk("t6_single_pulse", 32'(pulses - pb), 32'd1);
    chk("t6_no_repeat_offset", 32'(off[0]), 32'(pulse_at[pb] - t0));
`endif
    pressed = '0;
    wait_release("t6", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
